// File: rtl/rr_sel_arbiter_pkg.sv
// Shared constants and types for the round-robin select arbiter slice.
// Imported by the arbiter top; the mux leaf is self-contained.
package rr_sel_arbiter_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Occupancy of the single output slot; out_valid is decoded from it.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rr_sel_arbiter_mux.sv
// WIDTH-wide combinational 2:1 selector: out = sel ? b : a.
module sel_mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Arbitrates two valid/ready streams onto one registered output slot,
// driving the 2:1 select from a round-robin or fixed-priority grant.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  slot_state_t      state;
  logic             last_grant;
  logic             grant_vld;
  logic             grant_sel;
  logic             load_en;
  logic [WIDTH-1:0] mux_out;

  assign out_valid = (state == SLOT_FULL);

  // Slot refills in the same cycle it drains, giving one word per cycle.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = last_grant;
    if (MODE == MODE_FIXED) begin
      if (a_valid) begin
        grant_vld = 1'b1;
        grant_sel = SEL_A;
      end else if (b_valid) begin
        grant_vld = 1'b1;
        grant_sel = SEL_B;
      end
    end else begin
      unique case ({a_valid, b_valid})
        2'b10: begin
          grant_vld = 1'b1;
          grant_sel = SEL_A;
        end
        2'b01: begin
          grant_vld = 1'b1;
          grant_sel = SEL_B;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_sel = ~last_grant;
        end
        default: begin
          grant_vld = 1'b0;
          grant_sel = last_grant;
        end
      endcase
    end
  end

  assign sel     = grant_sel;
  assign a_ready = !rst && load_en && grant_vld && (grant_sel == SEL_A);
  assign b_ready = !rst && load_en && grant_vld && (grant_sel == SEL_B);

  sel_mux2 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(grant_sel),
    .a  (a),
    .b  (b),
    .out(mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SLOT_EMPTY;
      out        <= '0;
      out_src    <= SEL_A;
      last_grant <= SEL_B;
    end else if (load_en) begin
      if (grant_vld) begin
        out     <= mux_out;
        out_src <= grant_sel;
        state   <= SLOT_FULL;
        if (MODE == MODE_RR) begin
          last_grant <= grant_sel;
        end
      end else begin
        // load_en with a full slot implies out_ready, so the word drained.
        state <= SLOT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus;
// a reference model queues expected words and a monitor checks each drain.
module tb_rr_sel_arbiter;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    bit           s;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         a_valid, b_valid, out_ready;

  logic [1:0]   ar, br, sl, osrc, ovld;
  logic [W-1:0] ov [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance (0 = round-robin, 1 = fixed priority).
  bit    m_full [2];
  int    m_last [2];
  word_t q0[$];
  word_t q1[$];

  always #5 clk = ~clk;

  rr_sel_arbiter #(.WIDTH(W), .MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .a(a), .a_valid(a_valid), .a_ready(ar[0]),
    .b(b), .b_valid(b_valid), .b_ready(br[0]),
    .sel(sl[0]), .out(ov[0]), .out_src(osrc[0]),
    .out_valid(ovld[0]), .out_ready(out_ready)
  );

  rr_sel_arbiter #(.WIDTH(W), .MODE(1)) u_fx (
    .clk(clk), .rst(rst),
    .a(a), .a_valid(a_valid), .a_ready(ar[1]),
    .b(b), .b_valid(b_valid), .b_ready(br[1]),
    .sel(sl[1]), .out(ov[1]), .out_src(osrc[1]),
    .out_valid(ovld[1]), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Which channel the policy serves: -1 none, 0 A, 1 B.
  function automatic int pick(int mode, bit av, bit bv, int last);
    if (mode == 1) return av ? 0 : (bv ? 1 : -1);
    if (av && bv) return 1 - last;
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 1'b0;
      m_last[d] = 1;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock of stimulus: drive at negedge, check handshake outputs, advance model at posedge.
  task automatic cyc(input bit r, input bit av, input logic [W-1:0] ad,
                     input bit bv, input logic [W-1:0] bd, input bit ordy);
    int    g [2];
    bit    ld [2];
    word_t w;
    @(negedge clk);
    rst = r; a_valid = av; a = ad; b_valid = bv; b = bd; out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]  = pick(d, av, bv, m_last[d]);
      ld[d] = !m_full[d] || ordy;
      chk(d == 0 ? "rr_a_ready" : "fx_a_ready", ar[d], !r && ld[d] && g[d] == 0);
      chk(d == 0 ? "rr_b_ready" : "fx_b_ready", br[d], !r && ld[d] && g[d] == 1);
      chk(d == 0 ? "rr_sel" : "fx_sel", sl[d], (g[d] < 0) ? m_last[d] : g[d]);
      chk(d == 0 ? "rr_out_valid" : "fx_out_valid", ovld[d], m_full[d]);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ld[d] && g[d] >= 0) begin
          w.d = (g[d] == 0) ? ad : bd;
          w.s = (g[d] == 1);
          if (d == 0) q0.push_back(w); else q1.push_back(w);
          m_full[d] = 1'b1;
          if (d == 0) m_last[d] = g[d];
        end else if (ld[d]) begin
          m_full[d] = 1'b0;
        end
      end
    end
  endtask

  // Monitor: whenever a slot is presented, compare against the scoreboard head; pop on drain.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0) begin
        for (int d = 0; d < 2; d++) begin
          if (ovld[d] === 1'b1) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              chk(d == 0 ? "rr_sb_pending" : "fx_sb_pending", 0, 1);
            end else begin
              e = (d == 0) ? q0[0] : q1[0];
              chk(d == 0 ? "rr_out" : "fx_out", ov[d], e.d);
              chk(d == 0 ? "rr_out_src" : "fx_out_src", osrc[d], e.s);
              if (out_ready === 1'b1) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; a = '0; b = '0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    model_reset();

    // Reset held with both channels requesting.
    cyc(1, 1, 8'h11, 1, 8'h22, 1);
    cyc(1, 1, 8'h11, 1, 8'h22, 1);
    #1;
    chk("rst_out_valid", ovld[0], 0);
    chk("rst_out", ov[0], 8'h00);
    chk("rst_out_src", osrc[0], 0);

    // Alternation on the round-robin instance.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h11, 1, 8'h22, 1);
      #1;
      chk("alt_out", ov[0], (i % 2 == 0) ? 8'h11 : 8'h22);
      chk("alt_src", osrc[0], i % 2);
      chk("fx_alt_out", ov[1], 8'h11);
    end

    // Backpressure: slot holds, no readies.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 8'h11, 1, 8'h22, 0);
      #1;
      chk("stall_out", ov[0], 8'h22);
    end
    cyc(0, 1, 8'h11, 1, 8'h22, 1);
    #1;
    chk("stall_release", ov[0], 8'h11);

    // Single source B, then A joins and wins the tie.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'h00, 1, 8'h5A, 1);
      #1;
      chk("solo_b_out", ov[0], 8'h5A);
      chk("solo_b_src", osrc[0], 1);
    end
    cyc(0, 1, 8'hA5, 1, 8'h5A, 1);
    #1;
    chk("join_a_out", ov[0], 8'hA5);

    // Fixed priority: A always wins, B only once A drops.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h3C, 1, 8'hC3, 1);
      #1;
      chk("fx_prio_out", ov[1], 8'h3C);
      chk("fx_prio_src", osrc[1], 0);
    end
    cyc(0, 0, 8'h3C, 1, 8'hC3, 1);
    #1;
    chk("fx_b_after_drop", ov[1], 8'hC3);

    // Mid-operation reset discards the held word; next tie goes to A.
    cyc(0, 1, 8'h33, 0, 8'h00, 0);
    cyc(1, 1, 8'h44, 1, 8'h55, 0);
    #1;
    chk("midrst_out_valid", ovld[0], 0);
    cyc(0, 1, 8'h44, 1, 8'h55, 1);
    #1;
    chk("midrst_tie_a", ov[0], 8'h44);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, W'($urandom),
          $urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) != 0);
    end
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
